// File: rtl/fifo_rd_stream_pkg.sv
// Shared defaults and helpers for the async FIFO read-side stream logic.
// The async FIFO benches import this package as well.
package fifo_rd_stream_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int PKT_LEN_DEF   = 4;
  localparam int CNT_W_DEF     = 16;

  // Bit 0 is "O holds a word", bit 1 is "S holds a word", so both flags are plain flops.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b11
  } skid_occ_e;

  function automatic int beat_width(input int pkt_len);
    if ($clog2(pkt_len) < 1) begin
      beat_width = 1;
    end else begin
      beat_width = $clog2(pkt_len);
    end
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus outgoing valid/ready stream, bundled for the read-side consumer.
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int CNT_W     = CNT_W_DEF
) ();

  logic                 rempty;
  logic [DATA_SIZE-1:0] rdata;
  logic                 rinc;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_last;
  logic [CNT_W-1:0]     pkt_cnt;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data, m_last, pkt_cnt
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data, m_last, pkt_cnt
  );

endinterface

// File: rtl/fifo_rd_stream_skid_buffer.sv
// Two-entry skid buffer: main register O drives the stream, S absorbs one word of backpressure.
module skid_buffer
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data
);

  skid_occ_e            occ_r;
  skid_occ_e            occ_nxt_s;
  logic [DATA_SIZE-1:0] o_data_r;
  logic [DATA_SIZE-1:0] s_data_r;
  logic                 push_s;
  logic                 pop_s;
  logic                 load_o_in_s;
  logic                 load_o_skid_s;
  logic                 load_s_s;

  // Readiness depends only on the registered S flag, never on m_ready.
  assign in_ready = !occ_r[1] && !rst;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = occ_r[0] && m_ready;
  assign m_valid  = occ_r[0];
  assign m_data   = o_data_r;

  // Occupancy next-state and register load selects.
  always_comb begin
    occ_nxt_s     = occ_r;
    load_o_in_s   = 1'b0;
    load_o_skid_s = 1'b0;
    load_s_s      = 1'b0;
    case (occ_r)
      OCC_EMPTY: begin
        if (push_s) begin
          load_o_in_s = 1'b1;
          occ_nxt_s   = OCC_ONE;
        end else begin
          occ_nxt_s = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (push_s && pop_s) begin
          load_o_in_s = 1'b1;
          occ_nxt_s   = OCC_ONE;
        end else if (push_s) begin
          load_s_s  = 1'b1;
          occ_nxt_s = OCC_FULL;
        end else if (pop_s) begin
          occ_nxt_s = OCC_EMPTY;
        end else begin
          occ_nxt_s = OCC_ONE;
        end
      end
      OCC_FULL: begin
        if (pop_s) begin
          load_o_skid_s = 1'b1;
          occ_nxt_s     = OCC_ONE;
        end else begin
          occ_nxt_s = OCC_FULL;
        end
      end
      default: begin
        occ_nxt_s = OCC_EMPTY;
      end
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= OCC_EMPTY;
    end else begin
      occ_r <= occ_nxt_s;
    end
  end

  // Data registers for O and S.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data_r <= {DATA_SIZE{1'b0}};
      s_data_r <= {DATA_SIZE{1'b0}};
    end else begin
      if (load_o_in_s) begin
        o_data_r <= in_data;
      end else if (load_o_skid_s) begin
        o_data_r <= s_data_r;
      end else begin
        o_data_r <= o_data_r;
      end
      if (load_s_s) begin
        s_data_r <= in_data;
      end else begin
        s_data_r <= s_data_r;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops FWFT words into a skid buffer and frames the
// resulting stream into fixed-length packets with a completed-packet counter.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int PKT_LEN   = PKT_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic               rclk,
  input logic               rrst,
  fifo_rd_stream_if.master  bus
);

  localparam int                BEAT_W    = beat_width(PKT_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic                 in_valid_s;
  logic                 in_ready_s;
  logic                 m_valid_s;
  logic [DATA_SIZE-1:0] m_data_s;
  logic                 hs_s;
  logic                 last_s;
  logic [BEAT_W-1:0]    beat_r;
  logic [CNT_W-1:0]     pkt_cnt_r;

  assign in_valid_s = !bus.rempty;
  assign bus.rinc   = in_valid_s && in_ready_s;

  skid_buffer #(
    .DATA_SIZE (DATA_SIZE)
  ) u_skid (
    .clk      (rclk),
    .rst      (rrst),
    .in_valid (in_valid_s),
    .in_ready (in_ready_s),
    .in_data  (bus.rdata),
    .m_valid  (m_valid_s),
    .m_ready  (bus.m_ready),
    .m_data   (m_data_s)
  );

  assign hs_s        = m_valid_s && bus.m_ready;
  assign last_s      = m_valid_s && (beat_r == LAST_BEAT);
  assign bus.m_valid = m_valid_s;
  assign bus.m_data  = m_data_s;
  assign bus.m_last  = last_s;
  assign bus.pkt_cnt = pkt_cnt_r;

  // Beat index advances on accepted words only, so empty-FIFO bubbles leave it alone.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      beat_r <= {BEAT_W{1'b0}};
    end else if (hs_s) begin
      if (beat_r == LAST_BEAT) begin
        beat_r <= {BEAT_W{1'b0}};
      end else begin
        beat_r <= beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      beat_r <= beat_r;
    end
  end

  // Completed-packet counter, wrapping naturally at its width.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pkt_cnt_r <= {CNT_W{1'b0}};
    end else if (hs_s && last_s) begin
      pkt_cnt_r <= pkt_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a directed vector table, corner-case sequences and random traffic,
// with two instances (PKT_LEN=4/CNT_W=16 and PKT_LEN=1/CNT_W=4) sharing the same inputs.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  logic rclk;
  logic rrst;

  fifo_rd_stream_if #(.DATA_SIZE(8), .CNT_W(16)) bus0 ();
  fifo_rd_stream_if #(.DATA_SIZE(8), .CNT_W(4))  bus1 ();

  fifo_rd_stream #(.DATA_SIZE(8), .PKT_LEN(4), .CNT_W(16)) dut0 (
    .rclk (rclk), .rrst (rrst), .bus (bus0.master));
  fifo_rd_stream #(.DATA_SIZE(8), .PKT_LEN(1), .CNT_W(4)) dut1 (
    .rclk (rclk), .rrst (rrst), .bus (bus1.master));

  assign bus1.rempty  = bus0.rempty;
  assign bus1.rdata   = bus0.rdata;
  assign bus1.m_ready = bus0.m_ready;

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic        rst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        ready;
    logic        e_rinc;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_last;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t       vecs[12];
  int         compared;
  int         mismatched;
  int         pops;
  logic       bubble;
  logic [7:0] fifo_q[$];
  logic [7:0] held_q[$];
  int         nbeats;
  logic [7:0] out_q[$];
  logic       out_last_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_pins();
    bus0.rempty = bubble || (fifo_q.size() == 0);
    bus0.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // Reference: the design holds a queue of at most two popped words; the head is on m_data.
  task automatic clock_cycle();
    logic       c_rst, c_rempty, c_ready, c_rinc, e_valid, e_rinc;
    logic [7:0] c_rdata;
    @(negedge rclk);
    c_rst    = rrst;
    c_rempty = bus0.rempty;
    c_rdata  = bus0.rdata;
    c_ready  = bus0.m_ready;
    c_rinc   = bus0.rinc;
    e_valid  = (held_q.size() > 0);
    e_rinc   = !c_rst && !c_rempty && (held_q.size() < 2);
    chk("rinc", bus0.rinc, e_rinc);
    chk("rinc_p1", bus1.rinc, e_rinc);
    chk("m_valid", bus0.m_valid, e_valid);
    chk("m_valid_p1", bus1.m_valid, e_valid);
    if (e_valid) begin
      chk("m_data", bus0.m_data, held_q[0]);
      chk("m_data_p1", bus1.m_data, held_q[0]);
    end
    chk("m_last", bus0.m_last, e_valid && ((nbeats % 4) == 3));
    chk("pkt_cnt", bus0.pkt_cnt, (nbeats / 4) % 65536);
    chk("m_last_p1", bus1.m_last, e_valid);
    chk("pkt_cnt_p1", bus1.pkt_cnt, nbeats % 16);
    if (bus0.m_valid && c_ready) begin
      out_q.push_back(bus0.m_data);
      out_last_q.push_back(bus0.m_last);
    end
    @(posedge rclk);
    #1;
    if (c_rinc) begin
      pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (c_rst) begin
      held_q.delete();
      nbeats = 0;
    end else begin
      if (e_valid && c_ready) begin
        void'(held_q.pop_front());
        nbeats++;
      end
      if (e_rinc) held_q.push_back(c_rdata);
    end
  endtask

  task automatic step();
    drive_pins();
    clock_cycle();
  endtask

  task automatic reset_one();
    rrst = 1'b1;
    bubble = 1'b0;
    fifo_q.delete();
    step();
    rrst = 1'b0;
    out_q.delete();
    out_last_q.delete();
  endtask

  initial begin
    logic [7:0] bp_exp[5];
    compared = 0; mismatched = 0; pops = 0; nbeats = 0; bubble = 1'b0;
    rrst = 1'b1;
    bus0.rempty = 1'b0; bus0.rdata = 8'h00; bus0.m_ready = 1'b1;

    // reset for two cycles with a non-empty FIFO, then stream i*i for i = 0..7
    vecs[0]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd0,  1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 8'd1,  1'b1, 1'b1, 1'b1, 8'd0,  1'b0, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 8'd4,  1'b1, 1'b1, 1'b1, 8'd1,  1'b0, 16'd0};
    vecs[5]  = '{1'b0, 1'b0, 8'd9,  1'b1, 1'b1, 1'b1, 8'd4,  1'b0, 16'd0};
    vecs[6]  = '{1'b0, 1'b0, 8'd16, 1'b1, 1'b1, 1'b1, 8'd9,  1'b1, 16'd0};
    vecs[7]  = '{1'b0, 1'b0, 8'd25, 1'b1, 1'b1, 1'b1, 8'd16, 1'b0, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 8'd36, 1'b1, 1'b1, 1'b1, 8'd25, 1'b0, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 8'd49, 1'b1, 1'b1, 1'b1, 8'd36, 1'b0, 16'd1};
    vecs[10] = '{1'b0, 1'b1, 8'd0,  1'b1, 1'b0, 1'b1, 8'd49, 1'b1, 16'd1};
    vecs[11] = '{1'b0, 1'b1, 8'd0,  1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 16'd2};

    @(posedge rclk);
    #1;
    for (int i = 0; i < 12; i++) begin
      rrst         = vecs[i].rst;
      bus0.rempty  = vecs[i].rempty;
      bus0.rdata   = vecs[i].rdata;
      bus0.m_ready = vecs[i].ready;
      #3;
      chk("vec_rinc", bus0.rinc, vecs[i].e_rinc);
      chk("vec_valid", bus0.m_valid, vecs[i].e_valid);
      chk("vec_last", bus0.m_last, vecs[i].e_last);
      chk("vec_cnt", bus0.pkt_cnt, vecs[i].e_cnt);
      if (vecs[i].e_valid || vecs[i].rst) chk("vec_data", bus0.m_data, vecs[i].e_data);
      clock_cycle();
    end

    // backpressure: 5 words queued, m_ready low -> only two pops, head word held
    reset_one();
    bp_exp = '{8'd0, 8'd1, 8'd4, 8'd9, 8'd16};
    for (int k = 0; k < 5; k++) fifo_q.push_back(bp_exp[k]);
    bus0.m_ready = 1'b0;
    pops = 0;
    repeat (6) step();
    chk("bp_pops", pops, 2);
    chk("bp_hold_data", bus0.m_data, 8'd0);
    chk("bp_fifo_left", fifo_q.size(), 3);
    bus0.m_ready = 1'b1;
    for (int i = 0; i < 20 && out_q.size() < 5; i++) step();
    chk("bp_count", out_q.size(), 5);
    for (int k = 0; k < 5 && k < out_q.size(); k++) chk("bp_order", out_q[k], bp_exp[k]);

    // bubbles: rempty alternates each cycle, framing follows word count
    reset_one();
    for (int k = 0; k < 6; k++) fifo_q.push_back(8'h10 + 8'(k));
    for (int i = 0; i < 40 && out_q.size() < 6; i++) begin
      step();
      bubble = ~bubble;
    end
    bubble = 1'b0;
    chk("bub_count", out_q.size(), 6);
    for (int k = 0; k < out_q.size(); k++) begin
      chk("bub_data", out_q[k], 8'h10 + 8'(k));
      chk("bub_last", out_last_q[k], (k % 4) == 3);
    end

    // reset mid-packet with O and S both full
    reset_one();
    for (int k = 0; k < 12; k++) fifo_q.push_back(8'h20 + 8'(k));
    for (int i = 0; i < 20 && out_q.size() < 2; i++) step();
    bus0.m_ready = 1'b0;
    repeat (3) step();
    drive_pins();
    #1;
    chk("mid_rinc_blocked", bus0.rinc, 1'b0);
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    bus0.m_ready = 1'b1;
    out_q.delete();
    out_last_q.delete();
    for (int i = 0; i < 20 && out_q.size() < 4; i++) step();
    chk("mid_count", out_q.size(), 4);
    for (int k = 0; k < out_q.size(); k++) chk("mid_last", out_last_q[k], k == 3);

    // counter wrap: 17 words -> 17 packets of one beat (mod 16) and 4 packets of four
    reset_one();
    for (int k = 0; k < 17; k++) fifo_q.push_back(8'(k * 3));
    for (int i = 0; i < 60 && out_q.size() < 17; i++) step();
    chk("wrap_count", out_q.size(), 17);
    chk("wrap_cnt_p1", bus1.pkt_cnt, 4'd1);
    chk("wrap_cnt_p0", bus0.pkt_cnt, 16'd4);

    // random traffic against the queue model
    reset_one();
    for (int i = 0; i < 500; i++) begin
      if (fifo_q.size() < 3 && $urandom_range(0, 3) == 0) begin
        for (int k = 0; k < 4; k++) fifo_q.push_back(8'($urandom_range(0, 255)));
      end
      bubble       = ($urandom_range(0, 3) == 0);
      bus0.m_ready = ($urandom_range(0, 2) != 0);
      rrst         = ($urandom_range(0, 79) == 0);
      step();
    end
    rrst = 1'b0;
    bubble = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
